// File: rtl/m_pingpong_frame_buf.sv
// Ping-pong sample store: fills one bank serially while the other full bank
// is presented in parallel to the FFT butterfly datapath. Optional bit-reversed
// slot ordering delivers DIT input order without a separate reorder pass.
module m_pingpong_frame_buf #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 32,
  parameter int BIT_REVERSE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [ADDR_WIDTH-1:0]         in_idx,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [DEPTH*DATA_WIDTH-1:0]   frame_data,
  output logic                          frame_bank
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                                state;
  logic [1:0][DEPTH-1:0][DATA_WIDTH-1:0] bank;
  logic                                  wr_bank, rd_bank;
  logic [ADDR_WIDTH-1:0]                 wr_cnt;
  logic                                  accept, complete, release_f;

  // Storage slot for sequence index n: identity or bit-reversed
  function automatic logic [ADDR_WIDTH-1:0] slot_of(input logic [ADDR_WIDTH-1:0] n);
    logic [ADDR_WIDTH-1:0] r;
    r = n;
    if (BIT_REVERSE != 0)
      for (int i = 0; i < ADDR_WIDTH; i++) r[ADDR_WIDTH-1-i] = n[i];
    return r;
  endfunction

  // Handshake decode; ready/valid come straight from the state register
  assign in_ready    = (state != TWO);
  assign frame_valid = (state != EMPTY);
  assign in_idx      = wr_cnt;
  assign frame_bank  = rd_bank;
  assign accept      = in_valid && in_ready;
  assign complete    = accept && (wr_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign release_f   = frame_valid && frame_ready;

  // Flatten the presented bank onto the parallel bus
  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign frame_data[k*DATA_WIDTH +: DATA_WIDTH] = bank[rd_bank][k];
  end

  // Fill counter, bank pointers, queue FSM and sample writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank    <= '0;
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      state   <= EMPTY;
    end else if (flush) begin
      // bank contents intentionally kept; only fill/queue state clears
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      state   <= EMPTY;
    end else begin
      if (accept) begin
        bank[wr_bank][slot_of(wr_cnt)] <= in_data;
        wr_cnt <= wr_cnt + 1'b1;  // wraps to 0 on frame completion
      end
      if (complete)  wr_bank <= ~wr_bank;
      if (release_f) rd_bank <= ~rd_bank;
      case (state)
        EMPTY:   if (complete) state <= ONE;
        ONE:     if (complete && !release_f) state <= TWO;
                 else if (release_f && !complete) state <= EMPTY;
        TWO:     if (release_f) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_m_pingpong_frame_buf.sv
// Directed bench for the ping-pong frame buffer: reset, single frame,
// backpressure, simultaneous complete/release, bit-reversed order, flush.
module tb_m_pingpong_frame_buf;

  localparam int AW = 5, DW = 16, D = 32;

  logic              clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic              in_valid = 1'b0, frame_ready = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              ir0, fv0, fb0, ir1, fv1, fb1;
  logic [AW-1:0]     idx0, idx1;
  logic [D*DW-1:0]   fd0, fd1;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  m_pingpong_frame_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D), .BIT_REVERSE(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_idx(idx0), .frame_valid(fv0), .frame_ready(frame_ready),
    .frame_data(fd0), .frame_bank(fb0));

  m_pingpong_frame_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D), .BIT_REVERSE(1)) dut_br (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_idx(idx1), .frame_valid(fv1), .frame_ready(frame_ready),
    .frame_data(fd1), .frame_bank(fb1));

  typedef struct {
    logic          fl, iv, fr;
    logic [DW-1:0] d;
    logic          e_ir, e_fv, e_fb;
    logic [AW-1:0] e_idx;
    logic [DW-1:0] e_s5;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
  endtask

  function automatic logic [DW-1:0] slot(input logic [D*DW-1:0] fd, input int k);
    return fd[k*DW +: DW];
  endfunction

  initial begin
    //        fl    iv    fr    d             ir    fv    fb    idx   s5
    tbl[0] = '{1'b1, 1'b1, 1'b1, 16'd77,  1'b1, 1'b0, 1'b0, 5'd0, 16'd205};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'd0,   1'b1, 1'b0, 1'b0, 5'd0, 16'd205};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'd300, 1'b1, 1'b0, 1'b0, 5'd1, 16'd205};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 16'd301, 1'b1, 1'b0, 1'b0, 5'd2, 16'd205};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 16'd302, 1'b1, 1'b0, 1'b0, 5'd3, 16'd205};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 16'd303, 1'b1, 1'b0, 1'b0, 5'd4, 16'd205};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'd304, 1'b1, 1'b0, 1'b0, 5'd5, 16'd205};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 16'd305, 1'b1, 1'b0, 1'b0, 5'd6, 16'd305};

    // T1: reset state, then async reset mid-fill
    step(); step();
    chk("rst_in_ready", 32'(ir0), 1);
    chk("rst_frame_valid", 32'(fv0), 0);
    chk("rst_in_idx", 32'(idx0), 0);
    chk("rst_frame_bank", 32'(fb0), 0);
    rst = 1'b0;
    step();
    for (int k = 0; k < 7; k++) send(DW'(50 + k));
    in_valid = 1'b0;
    chk("t1_idx_before", 32'(idx0), 7);
    #2 rst = 1'b1;
    #1;
    chk("t1_in_ready", 32'(ir0), 1);
    chk("t1_frame_valid", 32'(fv0), 0);
    chk("t1_in_idx", 32'(idx0), 0);
    chk("t1_fd_zero", 32'(|fd0), 0);
    chk("t1_br_fd_zero", 32'(|fd1), 0);
    step();
    rst = 1'b0;
    step();

    // T2 + T5: one contiguous frame, consumer stalled
    for (int k = 0; k < 31; k++) send(DW'(k));
    chk("t2_fv_before_last", 32'(fv0), 0);
    send(DW'(31));
    in_valid = 1'b0;
    chk("t2_frame_valid", 32'(fv0), 1);
    chk("t2_frame_bank", 32'(fb0), 0);
    chk("t2_in_ready", 32'(ir0), 1);
    chk("t2_in_idx", 32'(idx0), 0);
    for (int k = 0; k < D; k++) chk($sformatf("t2_slot%0d", k), 32'(slot(fd0, k)), k);
    chk("t5_fv", 32'(fv1), 1);
    chk("t5_slot0", 32'(slot(fd1, 0)), 0);
    chk("t5_slot1", 32'(slot(fd1, 1)), 16);
    chk("t5_slot2", 32'(slot(fd1, 2)), 8);
    chk("t5_slot3", 32'(slot(fd1, 3)), 24);
    chk("t5_slot31", 32'(slot(fd1, 31)), 31);

    // T3: second frame fills, writer blocked, then single release
    for (int k = 0; k < D; k++) send(DW'(100 + k));
    chk("t3_in_ready_full", 32'(ir0), 0);
    chk("t3_fv_full", 32'(fv0), 1);
    chk("t3_bank_full", 32'(fb0), 0);
    in_valid = 1'b1;
    in_data  = 16'd999;
    step(); step();
    chk("t3_held_idx", 32'(idx0), 0);
    chk("t3_held_ready", 32'(ir0), 0);
    chk("t3_held_slot0", 32'(slot(fd0, 0)), 0);
    in_valid    = 1'b0;
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("t3_rel_bank", 32'(fb0), 1);
    chk("t3_rel_slot0", 32'(slot(fd0, 0)), 100);
    chk("t3_rel_ready", 32'(ir0), 1);
    chk("t3_rel_fv", 32'(fv0), 1);

    // T4: last sample of next frame coincides with release
    for (int k = 0; k < 31; k++) send(DW'(200 + k));
    frame_ready = 1'b1;
    send(DW'(231));
    frame_ready = 1'b0;
    in_valid    = 1'b0;
    chk("t4_fv", 32'(fv0), 1);
    chk("t4_bank", 32'(fb0), 0);
    chk("t4_slot0", 32'(slot(fd0, 0)), 200);
    chk("t4_slot31", 32'(slot(fd0, 31)), 231);
    chk("t4_in_ready_one", 32'(ir0), 1);

    // T6: partial fill into bank 1, then flush with concurrent accept/release
    for (int k = 0; k < 12; k++) send(DW'(400 + k));
    in_valid = 1'b0;
    chk("t6_idx_pre", 32'(idx0), 12);
    for (int r = 0; r < 8; r++) begin
      flush       = tbl[r].fl;
      in_valid    = tbl[r].iv;
      frame_ready = tbl[r].fr;
      in_data     = tbl[r].d;
      step();
      chk($sformatf("t6_r%0d_ir", r), 32'(ir0), 32'(tbl[r].e_ir));
      chk($sformatf("t6_r%0d_fv", r), 32'(fv0), 32'(tbl[r].e_fv));
      chk($sformatf("t6_r%0d_fb", r), 32'(fb0), 32'(tbl[r].e_fb));
      chk($sformatf("t6_r%0d_idx", r), 32'(idx0), 32'(tbl[r].e_idx));
      chk($sformatf("t6_r%0d_s5", r), 32'(slot(fd0, 5)), 32'(tbl[r].e_s5));
    end
    flush       = 1'b0;
    frame_ready = 1'b0;
    for (int k = 306; k < 331; k++) send(DW'(k));
    chk("t6_fv_before_last", 32'(fv0), 0);
    chk("t6_idx_31", 32'(idx0), 31);
    send(DW'(331));
    in_valid = 1'b0;
    chk("t6_fv", 32'(fv0), 1);
    chk("t6_bank", 32'(fb0), 0);
    chk("t6_slot0", 32'(slot(fd0, 0)), 300);
    chk("t6_slot12", 32'(slot(fd0, 12)), 312);
    chk("t6_slot31", 32'(slot(fd0, 31)), 331);
    chk("t6_idx_wrap", 32'(idx0), 0);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("t6_drained_fv", 32'(fv0), 0);
    chk("t6_drained_bank", 32'(fb0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
